ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Downstream consumer of ps2_keyboard. Pops scan-code bytes from its FIFO via the ready/nextdata_n
//  handshake and parses PS/2 set-2 make/break/extended sequences. Tracks the currently held key,
//  its ASCII value and a BCD press counter for the seven-segment display logic in top.
// PARAMETERS
//  COUNT_REPEAT  0  1: typematic repeats of the held key increment press_cnt; 0: they do not
//  COUNT_EXT     1  1: E0-prefixed keys update state and counter; 0: parsed, then discarded
// PORTS
//  clk           in   1  system clock; only clock domain
//  rst           in   1  synchronous, active-high reset
//  data          in   8  ps2_keyboard FIFO head byte; valid while ready=1
//  ready         in   1  ps2_keyboard FIFO non-empty
//  overflow      in   1  ps2_keyboard FIFO overflow flag
//  nextdata_n    out  1  active-low pop strobe to ps2_keyboard
//  scan_code     out  8  last make code accepted (prefix bytes excluded)
//  ext_key       out  1  scan_code was E0-prefixed
//  ascii         out  8  lower-case ASCII for scan_code; 8'h00 when unmapped or ext_key=1
//  key_down      out  1  a key is currently held
//  key_event     out  1  one-cycle pulse on each counted press
//  press_cnt     out  8  two BCD digits {tens,ones}, 00..99
//  err           out  1  sticky; set when overflow=1 is sampled
// BEHAVIOUR
//  Reset: nextdata_n=1; scan_code, ascii, press_cnt=8'h00; ext_key, key_down, key_event, err=0.
//   Parser flags brk/ext are cleared. The handshake FSM returns to IDLE, also mid-sequence.
//  Handshake FSM (IDLE -> ACK -> SETTLE -> IDLE):
//   IDLE: ready=1 -> latch data into byte_q, go to ACK.
//   ACK: nextdata_n=0 for exactly this cycle; byte_q is parsed this cycle.
//   SETTLE: nextdata_n=1; one cycle so ps2_keyboard updates ready. Then back to IDLE.
//   Byte accepted in cycle N: nextdata_n low in N+1, outputs updated at the end of N+1.
//   Next byte is accepted no earlier than N+3. nextdata_n is never low outside ACK.
//  Parser, on the byte parsed in ACK:
//   8'hE0 -> ext flag set. 8'hF0 -> brk flag set. No other outputs change.
//   Other byte, brk=1 (release):
//    if code==scan_code and ext flag==ext_key, key_down<=0.
//    brk and ext flags are cleared. No count.
//   Other byte, brk=0 (make):
//    Repeat = key_down=1, code==scan_code and ext flag==ext_key.
//     Repeat: state is unchanged; it counts only if COUNT_REPEAT=1.
//    Otherwise: scan_code<=code, ext_key<=ext flag, key_down<=1, and the press is counted.
//    ext flag is cleared.
//    COUNT_EXT=0 with ext flag=1: the byte is dropped and the flags are cleared.
//   Counted press: key_event=1 for one cycle; press_cnt BCD increment.
//    Ones 9 -> 0 with a tens carry; 99 -> 00 wraps silently.
//   Two F0 in a row: brk stays set. E0 after F0: both flags are held.
//   ascii is registered in the same cycle as scan_code, from the LUT.
//  err: set on any cycle with overflow=1, cleared only by rst. Parsing continues after err.
//  ready dropping while in ACK or SETTLE is legal; the FSM completes the sequence anyway.
// STRUCTURE
//  ps2_defs.vh shared include:
//   PS2_BRK=8'hF0, PS2_EXT=8'hE0, handshake state encodings (2-bit), BCD width.
//  Sub-module ps2_ascii_lut: combinational 8-bit set-2 -> ASCII.
//   Letters, digits, space (8'h29), enter (8'h5A -> 8'h0D); all others 8'h00.
//  Top: handshake FSM, parser flags, held-key registers, BCD counter, err flag.
// TESTING (bench models the ps2_keyboard FIFO: pops on nextdata_n=0 at posedge)
//  1. Push 1C -> scan_code=1C, ascii=61, key_down=1, press_cnt=01, key_event exactly one cycle;
//     nextdata_n low exactly once.
//  2. Push 1C,1C,1C,F0,1C (COUNT_REPEAT=0) -> press_cnt stays 01, key_down=0 after the final byte;
//     5 pops total.
//  3. Push E0,75,E0,F0,75 -> ext_key=1, scan_code=75, ascii=00, cnt+1, then key_down=0;
//     repeat with COUNT_EXT=0 -> no change.
//  4. 100 make/break pairs of 16 (key '1') -> press_cnt steps 09->10 and 99->00;
//     ascii=31; final press_cnt=00.
//  5. Push F0, assert rst one cycle, then push 1C -> 1C treated as a make:
//     press_cnt=01, key_down=1.
//  6. Hold overflow=1 one cycle -> err=1 and stays 1; next byte is still parsed;
//     rst clears err.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants, handshake state type and BCD helper for the PS/2 key decoder.
// Imported by the FIFO interface, the ASCII LUT and the decoder top.
package ps2_key_decoder_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BCD_W  = 8;

  localparam logic [DATA_W-1:0] PS2_BRK = 8'hF0;
  localparam logic [DATA_W-1:0] PS2_EXT = 8'hE0;

  typedef enum logic [1:0] {
    HS_IDLE   = 2'b00,
    HS_ACK    = 2'b01,
    HS_SETTLE = 2'b10
  } hs_state_t;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [3:0] ones_s;
    logic [3:0] tens_s;
    ones_s = v[3:0];
    tens_s = v[7:4];
    if (ones_s == 4'd9) begin
      ones_s = 4'd0;
      if (tens_s == 4'd9) begin
        tens_s = 4'd0;
      end else begin
        tens_s = tens_s + 4'd1;
      end
    end else begin
      ones_s = ones_s + 4'd1;
    end
    return {tens_s, ones_s};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-FIFO link between ps2_keyboard (master) and its consumer (slave).
// nextdata_n is the active-low pop strobe driven by the consumer.
interface ps2_key_decoder_if;
  import ps2_key_decoder_pkg::*;

  logic [DATA_W-1:0] data;
  logic              ready;
  logic              overflow;
  logic              nextdata_n;

  modport master (output data, output ready, output overflow, input nextdata_n);
  modport slave  (input data, input ready, input overflow, output nextdata_n);

endinterface

// File: rtl/ps2_key_decoder_ascii_lut.sv
// Combinational PS/2 set-2 scan code to lower-case ASCII lookup.
// Letters, digits, space and enter are mapped; every other code yields 8'h00.
module ps2_key_decoder_ascii_lut
  import ps2_key_decoder_pkg::*;
(
  input  logic [DATA_W-1:0] code,
  output logic [7:0]        ascii
);

  // Scan code table lookup
  always_comb begin
    case (code)
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops scan-code bytes from the ps2_keyboard FIFO and tracks the held key,
// its ASCII value and a BCD press counter; err latches any FIFO overflow.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter bit COUNT_REPEAT = 1'b0,
  parameter bit COUNT_EXT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  ps2_key_decoder_if.slave  fifo,
  output logic [DATA_W-1:0] scan_code,
  output logic              ext_key,
  output logic [7:0]        ascii,
  output logic              key_down,
  output logic              key_event,
  output logic [BCD_W-1:0]  press_cnt,
  output logic              err
);

  hs_state_t         state_r;
  logic [DATA_W-1:0] byte_r;
  logic              brk_r;
  logic              ext_r;
  logic [7:0]        lut_ascii_s;
  logic              match_s;
  logic              take_s;
  logic              count_s;

  ps2_key_decoder_ascii_lut u_lut (
    .code  (byte_r),
    .ascii (lut_ascii_s)
  );

  // Classify the latched byte: new press (take) and/or counted press
  always_comb begin
    match_s = (byte_r == scan_code) && (ext_r == ext_key);
    take_s  = 1'b0;
    count_s = 1'b0;
    if ((byte_r == PS2_EXT) || (byte_r == PS2_BRK) || brk_r) begin
      take_s  = 1'b0;
      count_s = 1'b0;
    end else if (ext_r && !COUNT_EXT) begin
      take_s  = 1'b0;
      count_s = 1'b0;
    end else if (key_down && match_s) begin
      take_s  = 1'b0;
      count_s = COUNT_REPEAT;
    end else begin
      take_s  = 1'b1;
      count_s = 1'b1;
    end
  end

  // Handshake FSM, parser flags, held-key state, press counter and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= HS_IDLE;
      fifo.nextdata_n <= 1'b1;
      byte_r          <= 8'h00;
      brk_r           <= 1'b0;
      ext_r           <= 1'b0;
      scan_code       <= 8'h00;
      ext_key         <= 1'b0;
      ascii           <= 8'h00;
      key_down        <= 1'b0;
      key_event       <= 1'b0;
      press_cnt       <= 8'h00;
      err             <= 1'b0;
    end else begin
      key_event <= 1'b0;
      err       <= err | fifo.overflow;
      case (state_r)
        HS_IDLE: begin
          if (fifo.ready) begin
            byte_r          <= fifo.data;
            fifo.nextdata_n <= 1'b0;
            state_r         <= HS_ACK;
          end else begin
            fifo.nextdata_n <= 1'b1;
          end
        end
        HS_ACK: begin
          fifo.nextdata_n <= 1'b1;
          state_r         <= HS_SETTLE;
          if (byte_r == PS2_EXT) begin
            ext_r <= 1'b1;
          end else if (byte_r == PS2_BRK) begin
            brk_r <= 1'b1;
          end else begin
            // Any terminal byte consumes both prefix flags
            brk_r <= 1'b0;
            ext_r <= 1'b0;
            if (brk_r && match_s) begin
              key_down <= 1'b0;
            end
            if (take_s) begin
              scan_code <= byte_r;
              ext_key   <= ext_r;
              ascii     <= ext_r ? 8'h00 : lut_ascii_s;
              key_down  <= 1'b1;
            end
            if (count_s) begin
              key_event <= 1'b1;
              press_cnt <= bcd_inc(press_cnt);
            end
          end
        end
        HS_SETTLE: begin
          fifo.nextdata_n <= 1'b1;
          state_r         <= HS_IDLE;
        end
        default: begin
          fifo.nextdata_n <= 1'b1;
          state_r         <= HS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: two decoders (default parameters, and COUNT_REPEAT=1/COUNT_EXT=0)
// are fed identical byte streams from modelled FIFOs and checked against a key-state model.
module tb_ps2_key_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       down;
    logic       brk;
    logic       extf;
    int         cnt;
  } model_t;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] code;
    logic       ext;
    logic [7:0] asc;
    logic       down;
    logic [7:0] cnt;
    logic       evt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovf = 1'b0;

  logic [7:0] sc   [2];
  logic       ek   [2];
  logic [7:0] asc  [2];
  logic       kd   [2];
  logic       kev  [2];
  logic [7:0] pcnt [2];
  logic       er   [2];

  logic [7:0] stim_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] code);
    logic [7:0] letters [26];
    logic [7:0] digits  [10];
    logic [7:0] r;
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    r = 8'h00;
    for (int i = 0; i < 26; i++) if (letters[i] == code) r = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == code) r = 8'h30 + 8'(i);
    if (code == 8'h29) r = 8'h20;
    if (code == 8'h5A) r = 8'h0D;
    return r;
  endfunction

  function automatic void model_step(input model_t si, input logic [7:0] b, input bit cr,
                                     input bit ce, output model_t so, output exp_t e);
    bit evt;
    so  = si;
    evt = 1'b0;
    if (b == 8'hE0) so.extf = 1'b1;
    else if (b == 8'hF0) so.brk = 1'b1;
    else if (si.brk) begin
      if (b == si.code && si.extf == si.ext) so.down = 1'b0;
      so.brk  = 1'b0;
      so.extf = 1'b0;
    end else begin
      if (si.extf && !ce) evt = 1'b0;
      else if (si.down && b == si.code && si.extf == si.ext) evt = cr;
      else begin
        so.code = b;
        so.ext  = si.extf;
        so.down = 1'b1;
        evt     = 1'b1;
      end
      so.extf = 1'b0;
    end
    if (evt) so.cnt = (si.cnt + 1) % 100;
    e.b    = b;
    e.code = so.code;
    e.ext  = so.ext;
    e.asc  = so.ext ? 8'h00 : ref_ascii(so.code);
    e.down = so.down;
    e.cnt  = 8'(((so.cnt / 10) << 4) | (so.cnt % 10));
    e.evt  = evt;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit CR = (g == 1);
    localparam bit CE = (g == 0);

    ps2_key_decoder_if bus ();
    assign bus.overflow = ovf;

    ps2_key_decoder #(.COUNT_REPEAT(CR), .COUNT_EXT(CE)) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo      (bus),
      .scan_code (sc[g]),
      .ext_key   (ek[g]),
      .ascii     (asc[g]),
      .key_down  (kd[g]),
      .key_event (kev[g]),
      .press_cnt (pcnt[g]),
      .err       (er[g])
    );

    logic [7:0] q [$];
    exp_t exq [$];
    model_t st = '0;
    int rd = 0;
    int pops = 0;
    int depth = 0;
    bit was_ack = 1'b0;
    bit prev_ack = 1'b0;
    bit exp_err = 1'b0;

    // FIFO model: takes new stimulus, pops during the ACK cycle, presents the head byte
    always @(negedge clk) begin
      exp_t e;
      while (rd < stim_q.size()) begin
        q.push_back(stim_q[rd]);
        model_step(st, stim_q[rd], CR, CE, st, e);
        exq.push_back(e);
        rd++;
      end
      was_ack = (bus.nextdata_n === 1'b0);
      if (was_ack && prev_ack) check($sformatf("dut%0d nextdata_n low twice", g), 64'd1, 64'd0);
      prev_ack = was_ack;
      if (was_ack) begin
        pops++;
        if (q.size() > 0) void'(q.pop_front());
      end
      bus.ready = (q.size() != 0);
      bus.data  = (q.size() != 0) ? q[0] : 8'h00;
      depth     = q.size();
    end

    // Monitor: compares outputs after each parsed byte, and err/key_event every cycle
    always @(posedge clk) begin
      bit rst_s, ov_s, ack_s;
      exp_t e;
      rst_s = rst;
      ov_s  = ovf;
      ack_s = was_ack;
      #1;
      if (rst_s) begin
        st      = '0;
        exp_err = 1'b0;
        exq.delete();
      end else begin
        exp_err = exp_err | ov_s;
      end
      check($sformatf("dut%0d err", g), 64'(er[g]), 64'(exp_err));
      if (!rst_s && ack_s) begin
        if (exq.size() == 0) begin
          check($sformatf("dut%0d unexpected pop", g), 64'd1, 64'd0);
        end else begin
          e = exq.pop_front();
          check($sformatf("dut%0d parse byte %h {sc,ext,asc,down,cnt,evt}", g, e.b),
                64'({sc[g], ek[g], asc[g], kd[g], pcnt[g], kev[g]}),
                64'({e.code, e.ext, e.asc, e.down, e.cnt, e.evt}));
        end
      end else begin
        check($sformatf("dut%0d idle key_event", g), 64'(kev[g]), 64'd0);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    stim_q.push_back(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((g_dut[0].depth != 0 || g_dut[1].depth != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("drain timeout", 64'd1, 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    logic [7:0] pool [12];
    pool = '{8'h1C, 8'h32, 8'h16, 8'h29, 8'h5A, 8'h45, 8'h75, 8'h6B, 8'h05, 8'hE0, 8'hF0, 8'hF0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("dut%0d reset state", g),
            64'({sc[g], ek[g], asc[g], kd[g], kev[g], pcnt[g], er[g]}), 64'd0);
    check("reset nextdata_n", 64'(g_dut[0].bus.nextdata_n), 64'd1);

    // Single make
    p0 = g_dut[0].pops;
    push(8'h1C);
    drain();
    check("t1 pops", 64'(g_dut[0].pops - p0), 64'd1);
    check("t1 ascii", 64'(asc[0]), 64'h61);
    check("t1 press_cnt", 64'(pcnt[0]), 64'h01);

    // Typematic repeats then release
    p0 = g_dut[0].pops;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check("t2 pops", 64'(g_dut[0].pops - p0), 64'd5);
    check("t2 press_cnt", 64'(pcnt[0]), 64'h01);
    check("t2 key_down", 64'(kd[0]), 64'd0);

    // Extended key press and release
    push(8'hE0); push(8'h75);
    drain();
    check("t3 ext_key", 64'(ek[0]), 64'd1);
    check("t3 ascii ext", 64'(asc[0]), 64'h00);
    check("t3 press_cnt", 64'(pcnt[0]), 64'h02);
    check("t3 no-ext dut ext_key", 64'(ek[1]), 64'd0);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    check("t3 release", 64'(kd[0]), 64'd0);

    // 100 presses wrap the BCD counter
    pulse_rst();
    for (int i = 0; i < 100; i++) begin
      push(8'h16); push(8'hF0); push(8'h16);
    end
    drain();
    check("t4 ascii", 64'(asc[0]), 64'h31);
    check("t4 final cnt dut0", 64'(pcnt[0]), 64'h00);
    check("t4 final cnt dut1", 64'(pcnt[1]), 64'h00);

    // Reset clears a pending break prefix
    push(8'hF0);
    drain();
    pulse_rst();
    push(8'h1C);
    drain();
    check("t5 press_cnt", 64'(pcnt[0]), 64'h01);
    check("t5 key_down", 64'(kd[0]), 64'd1);

    // Sticky overflow error
    @(negedge clk); ovf = 1'b1;
    @(negedge clk); ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 err sticky", 64'(er[0]), 64'd1);
    push(8'hF0); push(8'h1C); push(8'h32);
    drain();
    check("t6 parse after err", 64'(sc[0]), 64'h32);
    pulse_rst();
    @(negedge clk);
    check("t6 err cleared", 64'(er[0]), 64'd0);

    // Random byte streams with the occasional overflow pulse and idle gaps
    for (int i = 0; i < 300; i++) begin
      push(pool[$urandom_range(0, 11)]);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      if (i == 150) begin
        @(negedge clk); ovf = 1'b1;
        @(negedge clk); ovf = 1'b0;
      end
    end
    drain();
    check("leftover dut0", 64'(g_dut[0].exq.size()), 64'd0);
    check("leftover dut1", 64'(g_dut[1].exq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
